// File: rtl/router_write_ctrl.sv
// Ingress sequencer for the 1x3 router: decodes the header, steers the packet into one of
// three FIFOs, checks packet parity and issues per-port soft resets for unread outputs.
module router_write_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int TO_W    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       byte_valid,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic [2:0] write_enb,
    output logic [7:0] fifo_din,
    output logic       lfd_state,
    output logic [2:0] soft_reset,
    output logic       parity_err,
    output logic       pkt_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD_HDR,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK,
        DISCARD
    } state_t;

    state_t          r_state;
    logic [7:0]      r_hdr;
    logic [7:0]      r_parity;
    logic [5:0]      r_len;
    logic            r_aborted;
    logic [2:0]      r_soft_reset;
    logic            r_parity_err;
    logic            r_pkt_done;
    logic [TO_W-1:0] r_to_cnt [3];

    logic [1:0] w_addr;
    logic [3:0] w_full4;
    logic [3:0] w_empty4;
    logic [3:0] w_sr4;
    logic       w_loading;
    logic       w_abort;
    logic       w_busy;
    logic       w_accept;
    logic       w_write;
    logic [2:0] w_sel;

    // Address 2'b11 is padded to a zero flag so it can never stall, write or abort.
    always_comb begin
        w_addr    = r_hdr[1:0];
        w_full4   = {1'b0, fifo_full};
        w_empty4  = {1'b0, fifo_empty};
        w_sr4     = {1'b0, r_soft_reset};
        w_loading = (r_state == WAIT_EMPTY) || (r_state == LOAD_HDR) ||
                    (r_state == LOAD_DATA)  || (r_state == LOAD_PARITY);
        w_abort   = w_loading && w_sr4[w_addr];

        case (r_state)
            IDLE, DISCARD:          w_busy = 1'b0;
            LOAD_DATA, LOAD_PARITY: w_busy = w_full4[w_addr];
            default:                w_busy = 1'b1;
        endcase

        w_accept = byte_valid && !w_busy && !reset;
        w_write  = !reset && !w_abort &&
                   ((r_state == LOAD_HDR) ||
                    (((r_state == LOAD_DATA) || (r_state == LOAD_PARITY)) && w_accept));

        case (w_addr)
            2'd0:    w_sel = 3'b001;
            2'd1:    w_sel = 3'b010;
            2'd2:    w_sel = 3'b100;
            default: w_sel = 3'b000;
        endcase

        busy      = !reset && w_busy;
        write_enb = w_write ? w_sel : 3'b000;
        fifo_din  = reset ? 8'h00 : ((r_state == LOAD_HDR) ? r_hdr : data_in);
        lfd_state = w_write && (r_state == LOAD_HDR);
    end

    assign soft_reset = r_soft_reset;
    assign parity_err = r_parity_err;
    assign pkt_done   = r_pkt_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hdr        <= 8'h00;
            r_parity     <= 8'h00;
            r_len        <= 6'd0;
            r_aborted    <= 1'b0;
            r_soft_reset <= 3'b000;
            r_parity_err <= 1'b0;
            r_pkt_done   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_to_cnt[i] <= '0;
            end
        end else begin
            r_pkt_done   <= 1'b0;
            r_parity_err <= 1'b0;

            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i]) begin
                    r_to_cnt[i]     <= '0;
                    r_soft_reset[i] <= 1'b0;
                end else if (r_to_cnt[i] == TO_W'(TIMEOUT - 1)) begin
                    r_to_cnt[i]     <= '0;
                    r_soft_reset[i] <= 1'b1;
                end else begin
                    r_to_cnt[i]     <= r_to_cnt[i] + TO_W'(1);
                    r_soft_reset[i] <= 1'b0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hdr     <= data_in;
                        r_parity  <= data_in;
                        r_len     <= data_in[7:2];
                        r_aborted <= 1'b0;
                        r_state   <= (data_in[1:0] == 2'b11) ? DISCARD : WAIT_EMPTY;
                    end
                end
                WAIT_EMPTY: begin
                    if (w_abort) begin
                        r_pkt_done <= 1'b1;
                        r_aborted  <= 1'b1;
                        r_state    <= DISCARD;
                    end else if (w_empty4[w_addr]) begin
                        r_state <= LOAD_HDR;
                    end
                end
                LOAD_HDR: begin
                    if (w_abort) begin
                        r_pkt_done <= 1'b1;
                        r_aborted  <= 1'b1;
                        r_state    <= DISCARD;
                    end else begin
                        r_state <= (r_len == 6'd0) ? LOAD_PARITY : LOAD_DATA;
                    end
                end
                LOAD_DATA: begin
                    // A byte taken in the abort cycle is still consumed, so it leaves the remaining count.
                    if (w_abort) begin
                        r_pkt_done <= 1'b1;
                        r_aborted  <= 1'b1;
                        r_state    <= DISCARD;
                        if (w_accept) begin
                            r_len <= r_len - 6'd1;
                        end
                    end else if (w_accept) begin
                        r_parity <= r_parity ^ data_in;
                        r_len    <= r_len - 6'd1;
                        if (r_len == 6'd1) begin
                            r_state <= LOAD_PARITY;
                        end
                    end
                end
                LOAD_PARITY: begin
                    if (w_abort) begin
                        r_pkt_done <= 1'b1;
                        r_state    <= IDLE;
                    end else if (w_accept) begin
                        r_parity_err <= (data_in != r_parity);
                        r_pkt_done   <= 1'b1;
                        r_state      <= CHECK;
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                end
                DISCARD: begin
                    // An aborted packet already signalled completion when it was dropped.
                    if (w_accept) begin
                        if (r_len == 6'd0) begin
                            r_pkt_done <= !r_aborted;
                            r_state    <= IDLE;
                        end else begin
                            r_len <= r_len - 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_write_ctrl.sv
// Directed self-checking bench for router_write_ctrl: normal packets, parity error, FIFO stall,
// discard of address 3, per-port timeout and reset in the middle of a packet.
module tb_router_write_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       byte_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       busy;
    logic [2:0] write_enb;
    logic [7:0] fifo_din;
    logic       lfd_state;
    logic [2:0] soft_reset;
    logic       parity_err;
    logic       pkt_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct packed {
        logic [2:0] we;
        logic [7:0] din;
        logic       lfd;
    } wr_t;

    wr_t wrLog[$];
    int  pktCount;
    int  perrCount;
    int  lfdCount;
    int  srCount[3];

    router_write_ctrl #(.TIMEOUT(30), .TO_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .byte_valid (byte_valid),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .busy       (busy),
        .write_enb  (write_enb),
        .fifo_din   (fifo_din),
        .lfd_state  (lfd_state),
        .soft_reset (soft_reset),
        .parity_err (parity_err),
        .pkt_done   (pkt_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Record every FIFO write and every pulse seen in the middle of each cycle.
    always @(negedge clock) begin
        if (write_enb != 3'b000) wrLog.push_back({write_enb, fifo_din, lfd_state});
        if (pkt_done === 1'b1) pktCount++;
        if (parity_err === 1'b1) perrCount++;
        if (lfd_state === 1'b1) lfdCount++;
        for (int i = 0; i < 3; i++) if (soft_reset[i] === 1'b1) srCount[i]++;
    end

    task automatic clear_log;
        wrLog.delete();
        pktCount  = 0;
        perrCount = 0;
        lfdCount  = 0;
        for (int i = 0; i < 3; i++) srCount[i] = 0;
    endtask

    // Present one byte and hold it until the controller takes it; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok         = 1'b0;
        data_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: byte %h never accepted, busy=%b required 0", b, busy);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        byte_valid = 1'b1;
        data_in    = 8'hFF;
        fifo_full  = 3'b000;
        fifo_empty = 3'b000;
        read_enb   = 3'b000;
        wait_cycles(3);
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (write_enb !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_write_enb: got %b want 000", write_enb); end
        vectors++; if (fifo_din !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_fifo_din: got %h want 00", fifo_din); end
        vectors++; if (lfd_state !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_lfd: got %b want 0", lfd_state); end
        vectors++; if (soft_reset !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_soft_reset: got %b want 000", soft_reset); end
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_parity_err: got %b want 0", parity_err); end
        vectors++; if (pkt_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pkt_done: got %b want 0", pkt_done); end
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        fifo_empty = 3'b111;
        reset      = 1'b0;
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
        @(posedge clock);
        #1;
    endtask

    // Header 8'h38: len 14, addr 0; payload 1..14 gives parity 8'h38 ^ 8'h0F = 8'h37.
    task automatic test_good_packet;
        logic [7:0] expd[$];
        int c0;
        clear_log();
        c0 = cyc;
        send_byte(8'h38);
        for (int i = 1; i <= 14; i++) send_byte(8'(i));
        send_byte(8'h37);
        vectors++; if (cyc - c0 != 18) begin miscompares++; $display("[TB] FAIL good_cycles: got %0d want 18", cyc - c0); end
        @(negedge clock);
        vectors++; if (pkt_done !== 1'b1) begin miscompares++; $display("[TB] FAIL good_pkt_done: got %b want 1", pkt_done); end
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL good_parity_err: got %b want 0", parity_err); end
        wait_cycles(2);
        expd.push_back(8'h38);
        for (int i = 1; i <= 14; i++) expd.push_back(8'(i));
        expd.push_back(8'h37);
        vectors++; if (wrLog.size() != 16) begin miscompares++; $display("[TB] FAIL good_write_count: got %0d want 16", wrLog.size()); end
        for (int i = 0; i < 16 && i < wrLog.size(); i++) begin
            vectors++;
            if (wrLog[i].we !== 3'b001 || wrLog[i].din !== expd[i] || wrLog[i].lfd !== (i == 0)) begin
                miscompares++;
                $display("[TB] FAIL good_write[%0d]: got we=%b din=%h lfd=%b want we=001 din=%h lfd=%b",
                         i, wrLog[i].we, wrLog[i].din, wrLog[i].lfd, expd[i], (i == 0));
            end
        end
        vectors++; if (lfdCount != 1) begin miscompares++; $display("[TB] FAIL good_lfd_count: got %0d want 1", lfdCount); end
        vectors++; if (pktCount != 1) begin miscompares++; $display("[TB] FAIL good_pkt_count: got %0d want 1", pktCount); end
    endtask

    task automatic test_bad_parity;
        clear_log();
        send_byte(8'h38);
        for (int i = 1; i <= 14; i++) send_byte(8'(i));
        send_byte(8'h36);
        @(negedge clock);
        vectors++; if (parity_err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_parity_pulse: got %b want 1", parity_err); end
        vectors++; if (pkt_done !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_pkt_done: got %b want 1", pkt_done); end
        @(posedge clock);
        #1;
        @(negedge clock);
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL bad_parity_width: got %b want 0", parity_err); end
        wait_cycles(1);
        vectors++; if (wrLog.size() != 16) begin miscompares++; $display("[TB] FAIL bad_write_count: got %0d want 16", wrLog.size()); end
        if (wrLog.size() == 16) begin
            vectors++;
            if (wrLog[15].din !== 8'h36 || wrLog[15].we !== 3'b001) begin
                miscompares++;
                $display("[TB] FAIL bad_parity_written: got we=%b din=%h want we=001 din=36", wrLog[15].we, wrLog[15].din);
            end
        end
        vectors++; if (perrCount != 1) begin miscompares++; $display("[TB] FAIL bad_perr_count: got %0d want 1", perrCount); end
    endtask

    // Header 8'h19: len 6, addr 1; payload A0..A5 XORs to 8'h01, so parity = 8'h18.
    task automatic test_stall;
        logic [7:0] expd[8];
        expd = '{8'h19, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h18};
        clear_log();
        fork
            begin
                send_byte(8'h19);
                for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
                send_byte(8'h18);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(posedge clock);
                    #1;
                    if (wrLog.size() >= 4) begin
                        seen = 1'b1;
                        break;
                    end
                end
                vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL stall_start: got %0d writes want 4", wrLog.size()); end
                fifo_full = 3'b010;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    vectors++;
                    if (busy !== 1'b1 || write_enb !== 3'b000) begin
                        miscompares++;
                        $display("[TB] FAIL stall_cycle%0d: got busy=%b we=%b want busy=1 we=000", k, busy, write_enb);
                    end
                    @(posedge clock);
                    #1;
                end
                fifo_full = 3'b000;
                @(negedge clock);
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release: got busy=%b want 0", busy); end
            end
        join
        wait_cycles(2);
        vectors++; if (wrLog.size() != 8) begin miscompares++; $display("[TB] FAIL stall_write_count: got %0d want 8", wrLog.size()); end
        for (int i = 0; i < 8 && i < wrLog.size(); i++) begin
            vectors++;
            if (wrLog[i].we !== 3'b010 || wrLog[i].din !== expd[i]) begin
                miscompares++;
                $display("[TB] FAIL stall_write[%0d]: got we=%b din=%h want we=010 din=%h", i, wrLog[i].we, wrLog[i].din, expd[i]);
            end
        end
        vectors++; if (perrCount != 0) begin miscompares++; $display("[TB] FAIL stall_perr: got %0d want 0", perrCount); end
    endtask

    // Header 8'h13 (addr 3, len 4) drops 5 bytes; then header 8'h06 (len 1, addr 2), parity 8'h5C.
    task automatic test_discard;
        int c0;
        clear_log();
        c0 = cyc;
        send_byte(8'h13);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        vectors++; if (cyc - c0 != 6) begin miscompares++; $display("[TB] FAIL discard_cycles: got %0d want 6", cyc - c0); end
        @(negedge clock);
        vectors++; if (pkt_done !== 1'b1) begin miscompares++; $display("[TB] FAIL discard_pkt_done: got %b want 1", pkt_done); end
        vectors++; if (wrLog.size() != 0) begin miscompares++; $display("[TB] FAIL discard_writes: got %0d want 0", wrLog.size()); end
        @(posedge clock);
        #1;
        send_byte(8'h06);
        send_byte(8'h5A);
        send_byte(8'h5C);
        wait_cycles(2);
        vectors++; if (wrLog.size() != 3) begin miscompares++; $display("[TB] FAIL after_discard_count: got %0d want 3", wrLog.size()); end
        if (wrLog.size() == 3) begin
            vectors++;
            if (wrLog[0] !== {3'b100, 8'h06, 1'b1} || wrLog[1] !== {3'b100, 8'h5A, 1'b0} || wrLog[2] !== {3'b100, 8'h5C, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL after_discard_data: got %h %h %h want 80d 8b4 8b8", wrLog[0], wrLog[1], wrLog[2]);
            end
        end
        vectors++; if (pktCount != 2) begin miscompares++; $display("[TB] FAIL discard_pkt_count: got %0d want 2", pktCount); end
        vectors++; if (perrCount != 0) begin miscompares++; $display("[TB] FAIL discard_perr: got %0d want 0", perrCount); end
    endtask

    task automatic test_timeout;
        clear_log();
        fifo_empty = 3'b011;
        read_enb   = 3'b000;
        for (int n = 1; n <= 31; n++) begin
            @(posedge clock);
            @(negedge clock);
            vectors++;
            if (soft_reset !== ((n == 30) ? 3'b100 : 3'b000)) begin
                miscompares++;
                $display("[TB] FAIL timeout_cycle%0d: got %b want %b", n, soft_reset, (n == 30) ? 3'b100 : 3'b000);
            end
        end
        vectors++; if (srCount[2] != 1) begin miscompares++; $display("[TB] FAIL timeout_pulse_count: got %0d want 1", srCount[2]); end
        fifo_empty = 3'b111;
        @(posedge clock);
        #1;
        fifo_empty = 3'b011;
        for (int n = 1; n <= 50; n++) begin
            read_enb = (n == 29) ? 3'b100 : 3'b000;
            @(posedge clock);
            @(negedge clock);
            vectors++;
            if (soft_reset !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL timeout_read_cycle%0d: got %b want 000", n, soft_reset);
            end
        end
        read_enb   = 3'b000;
        fifo_empty = 3'b111;
        wait_cycles(2);
    endtask

    task automatic test_wait_empty_and_reset;
        clear_log();
        fifo_empty = 3'b011;
        send_byte(8'h0A);
        data_in    = 8'hC1;
        byte_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            vectors++;
            if (busy !== 1'b1 || write_enb !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL wait_empty_cycle%0d: got busy=%b we=%b want busy=1 we=000", k, busy, write_enb);
            end
            @(posedge clock);
            #1;
        end
        fifo_empty = 3'b111;
        send_byte(8'hC1);
        vectors++; if (wrLog.size() != 2) begin miscompares++; $display("[TB] FAIL wait_empty_writes: got %0d want 2", wrLog.size()); end
        reset      = 1'b1;
        data_in    = 8'hC2;
        byte_valid = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || write_enb !== 3'b000 || fifo_din !== 8'h00 || lfd_state !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midpkt_reset_comb: got busy=%b we=%b din=%h lfd=%b want 0 000 00 0", busy, write_enb, fifo_din, lfd_state);
        end
        @(posedge clock);
        #1;
        reset      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || write_enb !== 3'b000 || pkt_done !== 1'b0 || parity_err !== 1'b0 || soft_reset !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL midpkt_reset_idle: got busy=%b we=%b done=%b perr=%b sr=%b want all 0",
                     busy, write_enb, pkt_done, parity_err, soft_reset);
        end
        @(posedge clock);
        #1;
        clear_log();
        send_byte(8'h02);
        send_byte(8'h02);
        @(negedge clock);
        vectors++; if (pkt_done !== 1'b1 || parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_done: got done=%b perr=%b want 1 0", pkt_done, parity_err); end
        wait_cycles(2);
        vectors++;
        if (wrLog.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL post_reset_count: got %0d want 2", wrLog.size());
        end else if (wrLog[0] !== {3'b100, 8'h02, 1'b1} || wrLog[1] !== {3'b100, 8'h02, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL post_reset_data: got %h %h want 805 804", wrLog[0], wrLog[1]);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, required the test sequence to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        data_in    = 8'h00;
        byte_valid = 1'b0;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        clear_log();
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_stall();
        test_discard();
        test_timeout();
        test_wait_empty_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
